pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_gen_if.sv | 33 +++
 rtl/pc_ras.sv | 62 ++++++
 rtl/pc_gen.sv | 75 +++++++
 tb/tb_pc_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC source encoding for the fetch PC generator.
package pc_pkg;
  localparam int          XLEN_DEF         = 32;
  localparam int          INST_BYTES_DEF   = 4;
  localparam int          RAS_DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  // Listed highest priority first.
  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_REDIRECT,
    SRC_HOLD,
    SRC_RAS,
    SRC_SEQ
  } next_src_e;
endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle: fetch handshake, control-flow corrections and RAS hints.
interface pc_gen_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            ras_push;
  logic            ras_pop;
  logic [CW-1:0]   ras_count;

  // PC generator side.
  modport master (
    output fetch_valid, fetch_pc, ras_count,
    input  fetch_ready, stall, redirect_valid, redirect_pc,
           trap_valid, trap_pc, ras_push, ras_pop
  );

  // Fetch/pipeline side.
  modport slave (
    input  fetch_valid, fetch_pc, ras_count,
    output fetch_ready, stall, redirect_valid, redirect_pc,
           trap_valid, trap_pc, ras_push, ras_pop
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, a full push overwrites the oldest entry.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [XLEN-1:0]              wdata_i,
  output logic [XLEN-1:0]              top_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;   // next free slot; top lives at ptr_q-1
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx, wr_idx;
  logic            wr_en, nonempty;

  assign top_idx  = ptr_q - PW'(1);
  assign nonempty = (cnt_q != '0);
  assign top_o    = mem_q[top_idx];
  assign count_o  = cnt_q;

  // Pointer/count update and write slot selection.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i && nonempty) begin
      wr_en  = 1'b1;             // replace top in place
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en  = 1'b1;
      ptr_d  = ptr_q + PW'(1);   // wraps onto oldest entry when full
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && nonempty) begin
      ptr_d  = top_idx;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wr_idx] <= wdata_i;
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC register, valid flag, next-PC priority mux, incrementer.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              INST_BYTES   = INST_BYTES_DEF,
  parameter int              RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input logic       clk,
  input logic       rst_n,
  pc_gen_if.master  bus
);
  localparam int              CW         = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES) - XLEN'(1));

  logic [XLEN-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic            valid_q;
  logic            accept, ctl_flow, ras_push_en, ras_pop_en, ras_nonempty;
  logic [CW-1:0]   ras_cnt;
  next_src_e       src;

  assign accept       = valid_q & bus.fetch_ready & ~bus.stall;
  assign ctl_flow     = bus.trap_valid | bus.redirect_valid;
  assign pc_inc       = pc_q + XLEN'(INST_BYTES);   // wraps modulo 2^XLEN
  assign ras_nonempty = (ras_cnt != '0);
  assign ras_push_en  = accept & ~ctl_flow & bus.ras_push;
  assign ras_pop_en   = accept & ~ctl_flow & bus.ras_pop;

  // Next-PC source selection, highest priority first.
  always_comb begin
    src = SRC_SEQ;
    if (bus.trap_valid)                  src = SRC_TRAP;
    else if (bus.redirect_valid)         src = SRC_REDIRECT;
    else if (!accept)                    src = SRC_HOLD;
    else if (bus.ras_pop && ras_nonempty) src = SRC_RAS;
  end

  // Next-PC mux; correction targets are forced onto instruction alignment.
  always_comb begin
    pc_d = pc_inc;
    unique case (src)
      SRC_TRAP:     pc_d = bus.trap_pc & ALIGN_MASK;
      SRC_REDIRECT: pc_d = bus.redirect_pc & ALIGN_MASK;
      SRC_HOLD:     pc_d = pc_q;
      SRC_RAS:      pc_d = ras_top;
      default:      pc_d = pc_inc;
    endcase
  end

  // PC and valid registers; valid rises on the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ras_push_en),
    .pop_i   (ras_pop_en),
    .wdata_i (pc_inc),
    .top_o   (ras_top),
    .count_o (ras_cnt)
  );

  assign bus.fetch_pc    = pc_q;
  assign bus.fetch_valid = valid_q;
  assign bus.ras_count   = ras_cnt;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic vs. a queue-based model.
module tb_pc_gen;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .INST_BYTES(4), .RAS_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: PC, valid bit, RAS as a queue (back = most recent call).
  logic [31:0] m_pc;
  logic        m_vld;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.fetch_ready    = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.trap_valid     = 1'b0;
    bus.trap_pc        = '0;
    bus.ras_push       = 1'b0;
    bus.ras_pop        = 1'b0;
  endtask

  // Advance model one clock from the currently driven inputs.
  task automatic model_edge();
    logic        acc;
    logic [31:0] ret;
    if (!rst_n) begin
      m_pc  = RV;
      m_vld = 1'b0;
      m_ras.delete();
      return;
    end
    acc = m_vld && bus.fetch_ready && !bus.stall;
    ret = m_pc + 32'd4;
    if (bus.trap_valid)          m_pc = {bus.trap_pc[31:2], 2'b00};
    else if (bus.redirect_valid) m_pc = {bus.redirect_pc[31:2], 2'b00};
    else if (acc) begin
      if (bus.ras_pop && m_ras.size() > 0) begin
        m_pc = m_ras[$];
        if (bus.ras_push) m_ras[$] = ret;
        else void'(m_ras.pop_back());
      end else begin
        m_pc = ret;
        if (bus.ras_push) begin
          m_ras.push_back(ret);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
    m_vld = 1'b1;
  endtask

  // One clock: update model, then compare outputs shortly after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc",  bus.fetch_pc, m_pc);
    chk("vld", 32'(bus.fetch_valid), 32'(m_vld));
    chk("cnt", 32'(bus.ras_count), 32'(m_ras.size()));
  endtask

  task automatic goto(input logic [31:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = a;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [31:0] pops_pc [5] = '{32'h504, 32'h404, 32'h304, 32'h204, 32'h208};
  logic [31:0] pops_cnt[5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

  initial begin
    idle();
    rst_n = 1'b0;
    m_pc = RV; m_vld = 1'b0;

    // Reset release and straight-line fetch.
    step();
    step();
    chk("rst_vld", 32'(bus.fetch_valid), 32'd0);
    chk("rst_cnt", 32'(bus.ras_count), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_vld", 32'(bus.fetch_valid), 32'd1);
    chk("seq0", bus.fetch_pc, 32'h0);
    step(); chk("seq4", bus.fetch_pc, 32'h4);
    step(); chk("seq8", bus.fetch_pc, 32'h8);
    step(); chk("seqC", bus.fetch_pc, 32'hC);

    // Hold without ready; redirect overrides stall and is aligned.
    goto(32'h10);
    bus.fetch_ready = 1'b0;
    repeat (3) begin step(); chk("hold", bus.fetch_pc, 32'h10); end
    bus.stall = 1'b1;
    goto(32'h203);
    chk("redir_align", bus.fetch_pc, 32'h200);
    idle();

    // Trap beats redirect and pop; RAS untouched.
    bus.ras_push = 1'b1;
    step();
    bus.ras_push = 1'b0;
    bus.trap_valid = 1'b1; bus.trap_pc = 32'h800;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h400;
    bus.ras_pop = 1'b1;
    step();
    chk("trap_pc", bus.fetch_pc, 32'h800);
    chk("trap_cnt", 32'(bus.ras_count), 32'd1);
    idle();

    // Overflow the RAS with five calls, then five returns.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      goto(32'(i) << 8);
      bus.ras_push = 1'b1;
      step();
      bus.ras_push = 1'b0;
    end
    chk("ras_full", 32'(bus.ras_count), 32'd4);
    bus.ras_pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ras_pop_pc", bus.fetch_pc, pops_pc[i]);
      chk("ras_pop_cnt", 32'(bus.ras_count), pops_cnt[i]);
    end
    idle();

    // Increment wraps.
    goto(32'hFFFF_FFFC);
    step();
    chk("wrap", bus.fetch_pc, 32'h0);

    // Push+pop together, then reset overriding events.
    do_reset();
    goto(32'h100);
    bus.ras_push = 1'b1; step(); bus.ras_push = 1'b0;
    goto(32'h300);
    bus.ras_push = 1'b1; bus.ras_pop = 1'b1;
    step();
    chk("pp_pc", bus.fetch_pc, 32'h104);
    chk("pp_cnt", 32'(bus.ras_count), 32'd1);
    bus.ras_push = 1'b0;
    step();
    chk("pp_top", bus.fetch_pc, 32'h304);
    rst_n = 1'b0;
    bus.trap_valid = 1'b1; bus.trap_pc = 32'h900;
    bus.ras_push = 1'b1; bus.ras_pop = 1'b1;
    step();
    chk("rst_pc", bus.fetch_pc, RV);
    chk("rst_v2", 32'(bus.fetch_valid), 32'd0);
    chk("rst_c2", 32'(bus.ras_count), 32'd0);
    idle();
    rst_n = 1'b1;
    step();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      rst_n              = ($urandom_range(0, 99) != 0);
      bus.fetch_ready    = ($urandom_range(0, 3) != 0);
      bus.stall          = ($urandom_range(0, 6) == 0);
      bus.trap_valid     = ($urandom_range(0, 19) == 0);
      bus.trap_pc        = $urandom;
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                       : $urandom;
      bus.ras_push       = ($urandom_range(0, 3) == 0);
      bus.ras_pop        = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
